// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian word stream from the UART into RAM writes.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int DEPTH = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        we,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
   localparam state_t AfterData = CSUM;
`else
   typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE, ERR} state_t;
   localparam state_t AfterData = DONE;
`endif

   localparam logic [31:0] DepthW = 32'(DEPTH);

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] wordIdx_q, wordIdx_d;
   logic [1:0]  byteIdx_q, byteIdx_d;
   logic [23:0] asm_q, asm_d;
   logic        we_q, we_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] lenFull;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LEN0;
         count_q   <= '0;
         wordIdx_q <= '0;
         byteIdx_q <= '0;
         asm_q     <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wordIdx_q <= wordIdx_d;
         byteIdx_q <= byteIdx_d;
         asm_q     <= asm_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign lenFull = {rx_data, count_q[7:0]};

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wordIdx_d = wordIdx_q;
      byteIdx_d = byteIdx_q;
      asm_d     = asm_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         LEN0: begin
            if (rx_valid) begin
               count_d[7:0] = rx_data;
               state_d      = LEN1;
            end
         end
         LEN1: begin
            if (rx_valid) begin
               count_d   = lenFull;
               wordIdx_d = '0;
               byteIdx_d = '0;
               if ({16'd0, lenFull} > DepthW) begin
                  state_d = ERR;
               end else if (lenFull == 16'd0) begin
                  state_d = AfterData;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q + rx_data;
`endif
               byteIdx_d = byteIdx_q + 2'd1;
               case (byteIdx_q)
                  2'd0: asm_d[7:0]   = rx_data;
                  2'd1: asm_d[15:8]  = rx_data;
                  2'd2: asm_d[23:16] = rx_data;
                  default: begin
                     // Fourth byte completes the word; it goes straight to wdata without passing through asm_q.
                     we_d      = 1'b1;
                     wdata_d   = {rx_data, asm_q};
                     waddr_d   = {14'd0, wordIdx_q, 2'b00};
                     wordIdx_d = wordIdx_q + 16'd1;
                     if (wordIdx_q == count_q - 16'd1) begin
                        state_d = AfterData;
                     end
                  end
               endcase
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            if (rx_valid) begin
               state_d = (rx_data == csum_q) ? DONE : ERR;
            end
         end
`endif
         default: begin
            state_d = state_q;
         end
      endcase
   end

   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign cpu_hold = (state_q != DONE);
   assign done     = (state_q == DONE);
   assign error    = (state_q == ERR);

endmodule
